// File: rtl/wallace32.sv
// ---------------------------------------------------------------------------
// wallace32 -- 32x32 unsigned multiplier, Wallace-tree datapath, 1-cycle latency
//
// Structure:
//   1. 32 partial-product rows pp[j] = (A & {32{B[j]}}) << j, each 64 bits wide.
//   2. Carry-save reduction. Each layer groups its rows in threes and feeds
//      every group through a row of full adders (wallace32_csa), giving one sum
//      row and one carry row. Rows left over from the grouping pass straight
//      through. Row counts per layer are 32 -> 22 -> 15 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2.
//      In bit positions where an input row is structurally zero, a full adder
//      collapses to a half adder or a wire. Nothing ripples inside the tree.
//   3. The two remaining rows go through a 64-bit parallel-prefix carry-propagate
//      adder (wallace32_cpa).
//   4. The product is captured in prod_q on every rising edge.
//
// Ports (wallace32):
//   A      in   32  multiplicand, unsigned
//   B      in   32  multiplier, unsigned
//   prod   out  64  registered product A*B
//   clk    in   1   clock, rising edge
//   rst_n  in   1   synchronous active-low reset; clears prod
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// wallace32_csa -- 64-bit 3:2 compressor row (one full adder per bit)
//   a_i, b_i, c_i  in   64  three addend rows
//   s_o            out  64  bitwise sum row
//   c_o            out  64  carry row, already shifted to weight i+1
// A carry out of bit 63 has weight 2^64. The full product is below 2^64, so
// every row sum is exact modulo 2^64 and that carry is never produced.
// ---------------------------------------------------------------------------
module wallace32_csa (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic [63:0] c_i,
    output logic [63:0] s_o,
    output logic [63:0] c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = {(a_i[62:0] & b_i[62:0]) |
                  (a_i[62:0] & c_i[62:0]) |
                  (b_i[62:0] & c_i[62:0]), 1'b0};
endmodule

// ---------------------------------------------------------------------------
// wallace32_layer -- one Wallace reduction layer, NIN rows in, NOUT rows out
//   rows_i  in   NIN x 64   rows entering the layer
//   rows_o  out  NOUT x 64  rows leaving: {pass-through rows, carry, sum, ...}
// ---------------------------------------------------------------------------
module wallace32_layer #(
    parameter int NIN  = 3,
    parameter int NOUT = 2 * (NIN / 3) + (NIN % 3)
) (
    input  logic [NIN-1:0][63:0]  rows_i,
    output logic [NOUT-1:0][63:0] rows_o
);
    localparam int NG = NIN / 3;   // full 3:2 groups
    localparam int NP = NIN % 3;   // leftover rows, forwarded unchanged

    for (genvar g = 0; g < NG; g++) begin : g_csa
        wallace32_csa u_csa (
            .a_i (rows_i[3*g]),
            .b_i (rows_i[3*g+1]),
            .c_i (rows_i[3*g+2]),
            .s_o (rows_o[2*g]),
            .c_o (rows_o[2*g+1])
        );
    end

    for (genvar p = 0; p < NP; p++) begin : g_pass
        assign rows_o[2*NG+p] = rows_i[3*NG+p];
    end
endmodule

// ---------------------------------------------------------------------------
// wallace32_cpa -- 64-bit Kogge-Stone carry-propagate adder, carry-in 0
//   a_i, b_i  in   64  the two rows left by the tree
//   s_o       out  64  a_i + b_i mod 2^64 (carry out of bit 63 discarded)
// Only bits 62:0 need group generate/propagate terms. The carry into bit 63
// is the last carry that any sum bit uses.
// ---------------------------------------------------------------------------
module wallace32_cpa (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] s_o
);
    logic [62:0] gk, pk, gn, pn;

    always_comb begin
        gk = a_i[62:0] & b_i[62:0];
        pk = a_i[62:0] ^ b_i[62:0];
        gn = '0;
        pn = '0;
        // Six prefix levels at spans 1, 2, 4, 8, 16 and 32 cover all 63
        // positions. After the last level, gk[i] is the carry out of bit i.
        for (int lv = 0; lv < 6; lv++) begin
            gn = gk;
            pn = pk;
            for (int i = (1 << lv); i < 63; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i - (1 << lv)]);
                pn[i] = pk[i] & pk[i - (1 << lv)];
            end
            gk = gn;
            pk = pn;
        end
        s_o = (a_i ^ b_i) ^ {gk, 1'b0};
    end
endmodule

// ---------------------------------------------------------------------------
// wallace32 -- top
// ---------------------------------------------------------------------------
module wallace32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] prod,
    input  logic        clk,
    input  logic        rst_n
);
    localparam int W = 32;

    logic [W-1:0][63:0] pp;
    logic [21:0][63:0]  l1;
    logic [14:0][63:0]  l2;
    logic [9:0][63:0]   l3;
    logic [6:0][63:0]   l4;
    logic [4:0][63:0]   l5;
    logic [3:0][63:0]   l6;
    logic [2:0][63:0]   l7;
    logic [1:0][63:0]   l8;
    logic [63:0]        prod_d, prod_q;

    // Partial products: row j is A gated by B[j] and placed at weight 2^j.
    for (genvar j = 0; j < W; j++) begin : g_pp
        assign pp[j] = {32'h0, A & {W{B[j]}}} << j;
    end

    wallace32_layer #(.NIN(32)) u_lyr1 (.rows_i(pp), .rows_o(l1));
    wallace32_layer #(.NIN(22)) u_lyr2 (.rows_i(l1), .rows_o(l2));
    wallace32_layer #(.NIN(15)) u_lyr3 (.rows_i(l2), .rows_o(l3));
    wallace32_layer #(.NIN(10)) u_lyr4 (.rows_i(l3), .rows_o(l4));
    wallace32_layer #(.NIN(7))  u_lyr5 (.rows_i(l4), .rows_o(l5));
    wallace32_layer #(.NIN(5))  u_lyr6 (.rows_i(l5), .rows_o(l6));
    wallace32_layer #(.NIN(4))  u_lyr7 (.rows_i(l6), .rows_o(l7));
    wallace32_layer #(.NIN(3))  u_lyr8 (.rows_i(l7), .rows_o(l8));

    wallace32_cpa u_cpa (
        .a_i (l8[0]),
        .b_i (l8[1]),
        .s_o (prod_d)
    );

    // Reset has priority over the operands sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) prod_q <= 64'h0;
        else        prod_q <= prod_d;
    end

    assign prod = prod_q;
endmodule

// File: tb/tb_wallace32.sv
module tb_wallace32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, B;
    logic [63:0] prod;

    int n_checks = 0;
    int n_pass   = 0;

    wallace32 dut (
        .A     (A),
        .B     (B),
        .prod  (prod),
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: prod=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the value prod must hold after each rising edge,
    // taken from plain 64-bit arithmetic on the sampled operands.
    logic [63:0] exp_prod;
    bit          exp_vld = 1'b0;
    always @(posedge clk) begin
        exp_prod <= !rst_n ? 64'h0 : (64'(A) * 64'(B));
        exp_vld  <= 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (exp_vld) chk("model", prod, exp_prod);
    end

    // Drive operands after a falling edge, then check the literal one edge later.
    task automatic vec(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1 chk(name, prod, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        A     = 32'hDEADBEEF;
        B     = 32'h12345678;

        // Two reset edges with live operands: prod must stay 0.
        @(posedge clk);
        #1 chk("rst_edge1", prod, 64'h0);
        @(posedge clk);
        #1 chk("rst_edge2", prod, 64'h0);

        // Release. The first product appears on the first edge with rst_n high.
        @(negedge clk);
        rst_n = 1'b1;
        A     = 32'd7;
        B     = 32'd6;
        @(posedge clk);
        #1 chk("first_after_rst", prod, 64'd42);

        vec("dec_99999x4095",  32'h0001869F, 32'h00000FFF, 64'd409495905);
        vec("unsigned_opnd",   32'hFFFFFD72, 32'h0000007B, 64'h0000007AFFFEC5C6);
        vec("max_x_max",       32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        vec("zero_x_dead",     32'h00000000, 32'hDEADBEEF, 64'h0);
        vec("dead_x_zero",     32'hDEADBEEF, 32'h00000000, 64'h0);
        vec("one_x_b",         32'h00000001, 32'h12345678, 64'h0000000012345678);
        vec("msb_x_2",         32'h80000000, 32'h00000002, 64'h0000000100000000);
        vec("pow2_x_pow2",     32'h00010000, 32'h00010000, 64'h0000000100000000);
        vec("ffff_x_one",      32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF);

        // Operand change between edges: the last value before the edge wins.
        @(negedge clk);
        A = 32'h00000003;
        B = 32'h00000005;
        #2;
        A = 32'h00000010;
        B = 32'h00000011;
        @(posedge clk);
        #1 chk("late_change", prod, 64'h110);

        // Back-to-back random stream, one mid-stream reset edge.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            A = $urandom;
            B = $urandom;
            if (i == 500) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1 chk("midstream_rst", prod, 64'h0);
                @(negedge clk);
                rst_n = 1'b1;
                A = 32'hFFFFFFFF;
                B = 32'hFFFFFFFF;
                @(posedge clk);
                #1 chk("resume_after_rst", prod, 64'hFFFFFFFE00000001);
            end
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
